// File: rtl/dispenser_controller_if.sv
// Request/motor/status bundle between the vending machine (master) and the dispenser controller (slave).
interface dispenser_controller_if;
    logic product1;
    logic product2;
    logic product3;
    logic drop_sensor;
    logic motor1;
    logic motor2;
    logic motor3;
    logic delivered;
    logic busy;
    logic fault;

    modport master (
        output product1, product2, product3, drop_sensor,
        input  motor1, motor2, motor3, delivered, busy, fault
    );

    modport slave (
        input  product1, product2, product3, drop_sensor,
        output motor1, motor2, motor3, delivered, busy, fault
    );
endinterface

// File: rtl/dispenser_controller.sv
// Spiral-motor dispenser FSM: edge-triggered vend requests, timed motor run, delivered pulse.
// Define DROP_SENSOR_EN to require drop_sensor confirmation (with timeout into FAULT).
module dispenser_controller #(
    parameter int MOTOR_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int DELIVERED_CYCLES = 4
) (
    input logic                   clk,
    input logic                   reset,
    dispenser_controller_if.slave bus
);
    localparam int MAX_A   = (MOTOR_CYCLES > DELIVERED_CYCLES) ? MOTOR_CYCLES : DELIVERED_CYCLES;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] MOTOR_LAST     = CW'(MOTOR_CYCLES - 1);
    localparam logic [CW-1:0] DELIVERED_LAST = CW'(DELIVERED_CYCLES - 1);
`ifdef DROP_SENSOR_EN
    localparam logic [CW-1:0] TIMEOUT_LAST   = CW'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {IDLE, SPIN, WAIT_DROP, DONE, FAULT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    req, req_q, req_edge;
    logic [2:0]    sel_q, sel_d;
    logic [2:0]    motor_q, motor_d;
    logic          delivered_q, delivered_d;
    logic          busy_q, busy_d;
`ifdef DROP_SENSOR_EN
    logic          drop_q, drop_d;
    logic          fault_q, fault_d;
`endif

    assign req      = {bus.product3, bus.product2, bus.product1};
    assign req_edge = req & ~req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_q       <= '0;
            sel_q       <= '0;
            motor_q     <= '0;
            delivered_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DROP_SENSOR_EN
            drop_q      <= 1'b0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req;
            sel_q       <= sel_d;
            motor_q     <= motor_d;
            delivered_q <= delivered_d;
            busy_q      <= busy_d;
`ifdef DROP_SENSOR_EN
            drop_q      <= drop_d;
            fault_q     <= fault_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q + 1'b1;
`ifdef DROP_SENSOR_EN
        drop_d  = drop_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
`ifdef DROP_SENSOR_EN
                drop_d = 1'b0;
`endif
                // Lowest-index request wins; the rest are discarded, not queued.
                if (req_edge[0])      begin sel_d = 3'b001; state_d = SPIN; end
                else if (req_edge[1]) begin sel_d = 3'b010; state_d = SPIN; end
                else if (req_edge[2]) begin sel_d = 3'b100; state_d = SPIN; end
            end
            SPIN: begin
`ifdef DROP_SENSOR_EN
                drop_d = drop_q | bus.drop_sensor;
                if (cnt_q == MOTOR_LAST) state_d = (drop_q | bus.drop_sensor) ? DONE : WAIT_DROP;
`else
                if (cnt_q == MOTOR_LAST) state_d = DONE;
`endif
            end
`ifdef DROP_SENSOR_EN
            WAIT_DROP: begin
                // Sensor in the final cycle takes priority over the timeout.
                if (bus.drop_sensor)           state_d = DONE;
                else if (cnt_q == TIMEOUT_LAST) state_d = FAULT;
            end
            FAULT: begin
                cnt_d = cnt_q;
            end
`endif
            DONE: begin
                if (cnt_q == DELIVERED_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_comb begin
        motor_d     = (state_d == SPIN) ? sel_d : '0;
        delivered_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
`ifdef DROP_SENSOR_EN
        fault_d     = (state_d == FAULT);
`endif
    end

    assign bus.motor1    = motor_q[0];
    assign bus.motor2    = motor_q[1];
    assign bus.motor3    = motor_q[2];
    assign bus.delivered = delivered_q;
    assign bus.busy      = busy_q;
`ifdef DROP_SENSOR_EN
    assign bus.fault     = fault_q;
`else
    assign bus.fault     = 1'b0;
`endif
endmodule
